// File: rtl/delay_line_flow_controller.sv
// Valid/ready flow controller for an external CE-gated delay line.
// Tags each line stage with a valid bit and drains the line on FLUSH.
module delay_line_flow_controller #(
    parameter int DATA_BITS    = 32,
    parameter int DELAY_CYCLES = 16
) (
    input  logic                                  CLK,
    input  logic                                  RESET_N,
    input  logic                                  IN_VALID,
    output logic                                  IN_READY,
    input  logic [DATA_BITS-1:0]                  IN_VALUE,
    output logic                                  OUT_VALID,
    input  logic                                  OUT_READY,
    output logic [DATA_BITS-1:0]                  OUT_VALUE,
    input  logic                                  FLUSH,
    output logic                                  BUSY,
    output logic [$clog2(DELAY_CYCLES+1)-1:0]     OCCUPANCY,
    output logic                                  DL_CE,
    output logic [DATA_BITS-1:0]                  DL_IN_VALUE,
    input  logic [DATA_BITS-1:0]                  DL_OUT_VALUE
);

    localparam int OCC_BITS = $clog2(DELAY_CYCLES + 1);
    localparam int LAST     = DELAY_CYCLES - 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [LAST:0]         tag_q;
    logic [LAST:0]         tag_d;
    logic [OCC_BITS-1:0]   occ_q;
    logic [OCC_BITS-1:0]   occ_d;
    logic [DELAY_CYCLES:0] shift_ext;
    logic                  draining;
    logic                  can_adv;
    logic                  in_ready;
    logic                  in_fire;
    logic                  out_valid;
    logic                  out_fire;
    logic                  dl_ce;

    // Handshakes, line movement, tag/occupancy update and next state.
    always_comb begin
        state_d   = state_q;
        draining  = (state_q == DRAIN);
        can_adv   = ~tag_q[LAST] | OUT_READY;
        in_ready  = RESET_N & ~draining & can_adv;
        in_fire   = IN_VALID & in_ready;
        out_valid = RESET_N & tag_q[LAST];
        out_fire  = out_valid & OUT_READY;
        dl_ce     = RESET_N & can_adv & (in_fire | draining);
        shift_ext = {tag_q, in_fire};
        tag_d     = tag_q;
        if (dl_ce) begin
            tag_d = shift_ext[LAST:0];
        end else if (out_fire) begin
            // Output consumed while the line holds still: slot becomes a bubble.
            tag_d[LAST] = 1'b0;
        end
        occ_d = occ_q + OCC_BITS'(in_fire) - OCC_BITS'(out_fire);
        unique case (state_q)
            RUN: begin
                if (FLUSH && (occ_d != '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State register; reset drops all tags so stale line data is invisible.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= RUN;
            tag_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            occ_q   <= occ_d;
        end
    end

    assign IN_READY    = in_ready;
    assign OUT_VALID   = out_valid;
    assign OUT_VALUE   = DL_OUT_VALUE;
    assign BUSY        = RESET_N & (state_q == DRAIN);
    assign OCCUPANCY   = occ_q;
    assign DL_CE       = dl_ce;
    assign DL_IN_VALUE = draining ? '0 : IN_VALUE;

endmodule

// File: tb/tb_delay_line_flow_controller.sv
// Directed bench for delay_line_flow_controller with a behavioural
// CE-gated delay line attached.
module tb_delay_line_flow_controller;

    localparam int DB = 32;
    localparam int DC = 16;
    localparam int OW = $clog2(DC + 1);

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [DB-1:0] IN_VALUE = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [DB-1:0] OUT_VALUE;
    logic          FLUSH = 1'b0;
    logic          BUSY;
    logic [OW-1:0] OCCUPANCY;
    logic          DL_CE;
    logic [DB-1:0] DL_IN_VALUE;
    logic [DB-1:0] DL_OUT_VALUE;

    logic [DB-1:0] dl [DC];

    int total = 0;
    int bad   = 0;

    delay_line_flow_controller #(
        .DATA_BITS   (DB),
        .DELAY_CYCLES(DC)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_VALUE    (IN_VALUE),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_VALUE   (OUT_VALUE),
        .FLUSH       (FLUSH),
        .BUSY        (BUSY),
        .OCCUPANCY   (OCCUPANCY),
        .DL_CE       (DL_CE),
        .DL_IN_VALUE (DL_IN_VALUE),
        .DL_OUT_VALUE(DL_OUT_VALUE)
    );

    always #5 CLK = ~CLK;

    // External delay line: shifts one stage per enabled cycle.
    always @(posedge CLK) begin
        if (DL_CE) begin
            dl[0] <= DL_IN_VALUE;
            for (int i = 1; i < DC; i++) dl[i] <= dl[i-1];
        end
    end

    assign DL_OUT_VALUE = dl[DC-1];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        FLUSH     = 1'b0;
        OUT_READY = 1'b1;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic push5();
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1;
            IN_VALUE = DB'(c + 1);
            #1;
            chk("push_ready", IN_READY, 1);
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DC; i++) dl[i] = '0;

        // Reset held with IN_VALID asserted.
        RESET_N  = 1'b0;
        IN_VALID = 1'b1;
        IN_VALUE = 32'd77;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_in_ready", IN_READY, 0);
            chk("rst_dl_ce", DL_CE, 0);
            chk("rst_out_valid", OUT_VALID, 0);
            chk("rst_occ", OCCUPANCY, 0);
            chk("rst_busy", BUSY, 0);
        end
        RESET_N  = 1'b1;
        IN_VALID = 1'b0;
        #1;
        chk("post_rst_ready", IN_READY, 1);

        // Streaming 1..40 back-to-back.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            IN_VALID = 1'b1;
            IN_VALUE = DB'(c + 1);
            #1;
            chk("strm_ready", IN_READY, 1);
            chk("strm_occ", OCCUPANCY, (c < DC) ? c : DC);
            chk("strm_valid", OUT_VALID, (c >= DC) ? 1 : 0);
            if (c >= DC) chk("strm_value", OUT_VALUE, c - DC + 1);
            tick();
        end
        IN_VALID = 1'b0;

        // Sample-count hold: no input means no movement.
        do_reset();
        push5();
        for (int c = 0; c < 100; c++) begin
            #1;
            chk("hold_ce", DL_CE, 0);
            chk("hold_valid", OUT_VALID, 0);
            chk("hold_occ", OCCUPANCY, 5);
            tick();
        end

        // Backpressure.
        do_reset();
        OUT_READY = 1'b0;
        for (int c = 0; c < DC; c++) begin
            IN_VALID = 1'b1;
            IN_VALUE = DB'(c + 1);
            #1;
            chk("bp_fill_ready", IN_READY, 1);
            tick();
        end
        IN_VALUE = 32'd17;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", OUT_VALID, 1);
            chk("bp_value", OUT_VALUE, 1);
            chk("bp_ready", IN_READY, 0);
            chk("bp_ce", DL_CE, 0);
            chk("bp_occ", OCCUPANCY, DC);
            tick();
        end
        OUT_READY = 1'b1;
        #1;
        chk("bp_rel_ready", IN_READY, 1);
        chk("bp_rel_value", OUT_VALUE, 1);
        chk("bp_rel_ce", DL_CE, 1);
        tick();
        IN_VALID = 1'b0;
        #1;
        chk("bp_next_valid", OUT_VALID, 1);
        chk("bp_next_value", OUT_VALUE, 2);
        chk("bp_next_occ", OCCUPANCY, DC);
        tick();
        chk("bp_after_valid", OUT_VALID, 0);
        chk("bp_after_occ", OCCUPANCY, DC - 1);

        // Flush of five samples.
        do_reset();
        push5();
        FLUSH = 1'b1;
        #1;
        chk("fl_t_busy", BUSY, 0);
        tick();
        FLUSH = 1'b0;
        for (int k = 1; k <= DC; k++) begin
            #1;
            chk("fl_busy", BUSY, 1);
            chk("fl_ready", IN_READY, 0);
            chk("fl_dl_in", DL_IN_VALUE, 0);
            chk("fl_valid", OUT_VALID, (k >= 12) ? 1 : 0);
            if (k >= 12) chk("fl_value", OUT_VALUE, k - 11);
            tick();
        end
        chk("fl_end_busy", BUSY, 0);
        chk("fl_end_occ", OCCUPANCY, 0);
        chk("fl_end_valid", OUT_VALID, 0);

        // Flush on an empty line is ignored.
        do_reset();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("fe_busy", BUSY, 0);
        chk("fe_occ", OCCUPANCY, 0);

        // Flush together with an accepted sample on an empty line.
        FLUSH    = 1'b1;
        IN_VALID = 1'b1;
        IN_VALUE = 32'd9;
        #1;
        chk("fs_ready", IN_READY, 1);
        tick();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        for (int k = 1; k <= DC; k++) begin
            #1;
            chk("fs_busy", BUSY, 1);
            chk("fs_valid", OUT_VALID, (k == DC) ? 1 : 0);
            if (k == DC) chk("fs_value", OUT_VALUE, 9);
            tick();
        end
        chk("fs_end_busy", BUSY, 0);
        chk("fs_end_occ", OCCUPANCY, 0);

        // Reset in the middle of a drain.
        do_reset();
        push5();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        tick();
        tick();
        chk("rd_busy_before", BUSY, 1);
        RESET_N = 1'b0;
        tick();
        chk("rd_busy", BUSY, 0);
        chk("rd_occ", OCCUPANCY, 0);
        chk("rd_valid", OUT_VALID, 0);
        RESET_N = 1'b1;
        #1;
        chk("rd_rel_busy", BUSY, 0);
        chk("rd_rel_valid", OUT_VALID, 0);
        chk("rd_rel_ready", IN_READY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
